uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the UART data width.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum SysClk cycles from Tx_Start to Tx_Busy rising.
REQ-004 Port SysClk  in  1  single system clock; all logic on its rising edge.
REQ-005 Port Rst  in  1  reset, synchronous and active-low.
REQ-006 Port Req  in  NUM_REQ  per-requester transmit request, level.
REQ-007 Port Req_Data  in  NUM_REQ*DATA_BITS  per-requester byte; requester i owns slice [i*DATA_BITS +: DATA_BITS].
REQ-008 Port Gnt  out  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted.
REQ-009 Port Tx_Start  out  1  one-cycle pulse to UART transmitter.
REQ-010 Port Tx_Data  out  DATA_BITS  byte to transmitter, valid while Tx_Start is high.
REQ-011 Port Tx_Busy  in  1  transmitter busy flag.
REQ-012 Port CTS  in  1  clear-to-send; launches only while CTS is 1.
REQ-013 Port Err_Clr  in  1  clears Err.
REQ-014 Port Grant_Id  out  clog2(NUM_REQ)  index of the last granted requester.
REQ-015 Port Busy  out  1  high in every state except IDLE.
REQ-016 Port Err  out  1  sticky acknowledge-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
REQ-018 IDLE -> LAUNCH when |Req && CTS && !Tx_Busy; the winner is selected and Tx_Data latched on that edge.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer Ptr, ascending, wrapping at NUM_REQ-1 -> 0.
REQ-020 On a grant, Ptr SHALL become (winner+1) mod NUM_REQ.
REQ-021 In LAUNCH (exactly 1 cycle): Tx_Start=1, Gnt[winner]=1, Grant_Id=winner; then go to WAIT_ACK.
REQ-022 WAIT_ACK: count cycles; Tx_Busy=1 -> WAIT_DONE; count reaching ACK_TIMEOUT with Tx_Busy still 0 -> set Err and go to IDLE.
REQ-023 WAIT_DONE -> IDLE on the first cycle Tx_Busy=0.
REQ-024 Idle-to-idle latency SHALL be at least 3 cycles plus the transmitter busy time; Req sampled in IDLE only.
REQ-025 Requesters SHALL hold Req and Req_Data stable until Gnt; a Req dropped before the grant edge is not served.
REQ-026 Gnt and Tx_Start SHALL never be high for more than 1 consecutive cycle; Gnt SHALL be zero outside LAUNCH.
REQ-027 CTS falling during LAUNCH/WAIT_ACK/WAIT_DONE SHALL NOT abort the transfer; it only blocks the next IDLE -> LAUNCH.
REQ-028 Err_Clr=1 SHALL clear Err; a timeout on the same cycle takes priority (Err stays 1).
REQ-029 Tx_Data SHALL hold the last launched byte until the next launch.

Reset
REQ-030 While Rst=0 at a SysClk edge: state=IDLE, Ptr=0, counter=0, Gnt=0, Tx_Start=0, Tx_Data=0, Grant_Id=0, Busy=0, Err=0.
REQ-031 Reset asserted mid-operation SHALL abandon the transfer immediately, with no Gnt or Tx_Start pulse on the release cycle.

Verification
REQ-032 Fairness: Req=4'b1111 held, each Req_Data distinct, transmitter model busy 10 cycles -> Gnt order 0,1,2,3,0, and Tx_Data matches each granted slice.
REQ-033 Single requester: Req=4'b0100, Ptr=0 -> Gnt=4'b0100, Grant_Id=2, Tx_Start one pulse, next search starts at 3.
REQ-034 Flow control: CTS=0 with Req=4'b0001 for 50 cycles -> no Tx_Start; CTS=1 -> Tx_Start within 2 cycles.
REQ-035 Timeout: transmitter model never raises Tx_Busy -> Err=1 exactly ACK_TIMEOUT cycles after Tx_Start, state returns to IDLE; Err_Clr pulse -> Err=0.
REQ-036 Reset mid-transfer: Rst=0 during WAIT_DONE -> all outputs zero next cycle; after release, Req=4'b0010 is granted with Ptr starting at 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ byte sources onto one UART transmitter.
// Each transfer runs launch, acknowledge (with a timeout) and completion phases.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request with CTS high and transmitter free
// LAUNCH    | one-cycle Tx_Start / Gnt pulse for the latched winner
// WAIT_ACK  | waiting for Tx_Busy to rise; ack timer counting down
// WAIT_DONE | transmitter busy; return to IDLE when Tx_Busy falls
module uart_tx_arbiter #(
  parameter int DATA_BITS   = 8,
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                         SysClk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
  output logic [NUM_REQ-1:0]           Gnt,
  output logic                         Tx_Start,
  output logic [DATA_BITS-1:0]         Tx_Data,
  input  logic                         Tx_Busy,
  input  logic                         CTS,
  input  logic                         Err_Clr,
  output logic [$clog2(NUM_REQ)-1:0]   Grant_Id,
  output logic                         Busy,
  output logic                         Err
);

  localparam int          ID_W   = $clog2(NUM_REQ);
  localparam int          CNT_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned NREQ_U = NUM_REQ;
  // The launch cycle and the loading edge already account for two of the
  // ACK_TIMEOUT cycles, so the timer expires exactly ACK_TIMEOUT cycles after Tx_Start.
  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 2);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]           state;
  logic [ID_W-1:0]      ptr;
  logic [CNT_W-1:0]     ack_cnt;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      win_idx;
  logic                 win_found;
  logic [DATA_BITS-1:0] win_data;
  logic                 ack_timeout;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ_U) sum = sum - NREQ_U;
    return sum[ID_W-1:0];
  endfunction

  // Search upward from ptr, wrapping, and take the first active request.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_add(ptr, i);
      if (!win_found && Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) win_data = Req_Data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign ack_timeout = (state == WAIT_ACK) && !Tx_Busy && (ack_cnt == '0);

  always_ff @(posedge SysClk) begin
    if (!Rst) begin
      state    <= IDLE;
      ptr      <= '0;
      ack_cnt  <= '0;
      Tx_Data  <= '0;
      Grant_Id <= '0;
      Err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found && CTS && !Tx_Busy) begin
            state    <= LAUNCH;
            Grant_Id <= win_idx;
            Tx_Data  <= win_data;
            ptr      <= wrap_add(win_idx, 1);
          end
        end
        LAUNCH: begin
          state   <= WAIT_ACK;
          ack_cnt <= ACK_LOAD;
        end
        WAIT_ACK: begin
          if (Tx_Busy) begin
            state   <= WAIT_DONE;
            ack_cnt <= '0;
          end else if (ack_cnt == '0) begin
            state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!Tx_Busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A timeout on the same edge as Err_Clr wins.
      if (ack_timeout)  Err <= 1'b1;
      else if (Err_Clr) Err <= 1'b0;
    end
  end

  // Gnt and Tx_Start decode straight from LAUNCH so they can never outlast it.
  always_comb begin
    Gnt = '0;
    if (state == LAUNCH) Gnt[Grant_Id] = 1'b1;
  end

  assign Tx_Start = (state == LAUNCH);
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed phases push expected grants into a
// scoreboard that a negedge monitor drains; timing checks are made inline.
module tb_uart_tx_arbiter;

  logic        SysClk;
  logic        Rst;
  logic [3:0]  Req;
  logic [31:0] Req_Data;
  logic [3:0]  Gnt;
  logic        Tx_Start;
  logic [7:0]  Tx_Data;
  logic        Tx_Busy = 1'b0;
  logic        CTS;
  logic        Err_Clr;
  logic [1:0]  Grant_Id;
  logic        Busy;
  logic        Err;

  int checks    = 0;
  int failures  = 0;
  int gnt_seen  = 0;
  int busy_len  = 10;
  int busy_left = 0;
  bit no_ack    = 1'b0;
  bit prev_pulse = 1'b0;

  int         exp_id_q[$];
  logic [7:0] exp_data_q[$];

  uart_tx_arbiter #(.DATA_BITS(8), .NUM_REQ(4), .ACK_TIMEOUT(16)) dut (
    .SysClk   (SysClk),
    .Rst      (Rst),
    .Req      (Req),
    .Req_Data (Req_Data),
    .Gnt      (Gnt),
    .Tx_Start (Tx_Start),
    .Tx_Data  (Tx_Data),
    .Tx_Busy  (Tx_Busy),
    .CTS      (CTS),
    .Err_Clr  (Err_Clr),
    .Grant_Id (Grant_Id),
    .Busy     (Busy),
    .Err      (Err)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_id_q.push_back(id);
    exp_data_q.push_back(d);
  endtask

  task automatic wait_start(input string name, output int lat);
    lat = 0;
    while (!Tx_Start && lat < 100) begin
      @(negedge SysClk);
      lat++;
    end
    check(name, Tx_Start, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((Busy || Tx_Busy) && n < 200) begin
      @(negedge SysClk);
      n++;
    end
    check(name, Busy, 0);
  endtask

  // Transmitter model: busy for busy_len cycles after each Tx_Start unless no_ack.
  always @(negedge SysClk) begin
    if (!Rst) busy_left = 0;
    else if (Tx_Start && !no_ack) busy_left = busy_len;
    else if (busy_left > 0) busy_left = busy_left - 1;
    Tx_Busy = (busy_left > 0);
  end

  // Scoreboard monitor.
  always @(negedge SysClk) begin
    logic       pulse;
    int         id;
    logic [7:0] d;
    logic [3:0] exp_g;
    pulse = Tx_Start || (Gnt != 4'b0000);
    if (Rst && pulse) begin
      check("no_back_to_back", prev_pulse, 0);
      if (exp_id_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got Gnt=%b expected no grant", Gnt);
      end else begin
        id    = exp_id_q.pop_front();
        d     = exp_data_q.pop_front();
        exp_g = 4'b0001 << id;
        check("gnt_onehot", Gnt, exp_g);
        check("grant_id", Grant_Id, id);
        check("tx_data", Tx_Data, d);
        check("tx_start", Tx_Start, 1);
      end
      gnt_seen++;
    end
    prev_pulse = pulse;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    int starts;
    Rst = 1'b0; Req = 4'b0000; Req_Data = 32'h0; CTS = 1'b1; Err_Clr = 1'b0;
    repeat (3) @(negedge SysClk);
    check("rst_gnt", Gnt, 0);
    check("rst_tx_start", Tx_Start, 0);
    check("rst_tx_data", Tx_Data, 0);
    check("rst_grant_id", Grant_Id, 0);
    check("rst_busy", Busy, 0);
    check("rst_err", Err, 0);
    Rst = 1'b1;
    @(negedge SysClk);

    // Single requester from ptr 0, then ptr must sit at 3.
    Req_Data = 32'hD3C2B1A0;
    push(2, 8'hC2);
    Req = 4'b0100;
    wait_start("single_start", lat);
    Req = 4'b0000;
    wait_idle("single_idle");
    check("grant_id_hold", Grant_Id, 2);
    check("tx_data_hold", Tx_Data, 8'hC2);
    push(3, 8'hD3);
    Req = 4'b1001;
    wait_start("ptr_after_2", lat);
    Req = 4'b0000;
    wait_idle("ptr_idle");

    // Fairness: all four held, ptr at 0.
    Req_Data = 32'h44332211;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    Req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start("fair_start", lat);
      @(negedge SysClk);
    end
    Req = 4'b0000;
    wait_idle("fair_idle");

    // Flow control.
    Req_Data = 32'h5A6B7C8D;
    CTS = 1'b0;
    Req = 4'b0001;
    starts = 0;
    repeat (50) begin
      @(negedge SysClk);
      if (Tx_Start) starts++;
    end
    check("cts_block", starts, 0);
    push(0, 8'h8D);
    CTS = 1'b1;
    wait_start("cts_release", lat);
    check("cts_latency", (lat >= 1 && lat <= 2), 1);
    Req = 4'b0000;
    CTS = 1'b0;
    repeat (3) @(negedge SysClk);
    check("cts_no_abort", Busy, 1);
    wait_idle("cts_low_complete");
    CTS = 1'b1;

    // Acknowledge timeout, sticky Err, Err_Clr.
    no_ack = 1'b1;
    Req_Data = 32'h0000E100;
    push(1, 8'hE1);
    Req = 4'b0010;
    wait_start("to_start", lat);
    Req = 4'b0000;
    k = 0;
    while (!Err && k < 100) begin
      @(negedge SysClk);
      k++;
    end
    check("to_latency", k, 16);
    check("to_idle", Busy, 0);
    repeat (3) @(negedge SysClk);
    check("err_sticky", Err, 1);
    Err_Clr = 1'b1;
    @(negedge SysClk);
    check("err_clear", Err, 0);
    Err_Clr = 1'b0;

    // Timeout while Err_Clr is held: timeout wins its edge.
    Req_Data = 32'h00F20000;
    push(2, 8'hF2);
    Err_Clr = 1'b1;
    Req = 4'b0100;
    wait_start("to2_start", lat);
    Req = 4'b0000;
    k = 0;
    while (!Err && k < 100) begin
      @(negedge SysClk);
      k++;
    end
    check("to2_latency_clr_held", k, 16);
    @(negedge SysClk);
    check("err_clr_after_to", Err, 0);
    Err_Clr = 1'b0;
    no_ack = 1'b0;

    // Reset during WAIT_DONE; ptr was 3 before reset.
    Req_Data = 32'h005C0000;
    push(2, 8'h5C);
    Req = 4'b0100;
    wait_start("rst_phase_start", lat);
    Req = 4'b0000;
    repeat (4) @(negedge SysClk);
    check("wait_done_busy", Busy, 1);
    Rst = 1'b0;
    @(negedge SysClk);
    check("mid_rst_gnt", Gnt, 0);
    check("mid_rst_tx_start", Tx_Start, 0);
    check("mid_rst_tx_data", Tx_Data, 0);
    check("mid_rst_grant_id", Grant_Id, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_err", Err, 0);
    Req_Data = 32'h77006600;
    push(1, 8'h66);
    Req = 4'b1010;
    @(negedge SysClk);
    check("release_no_pulse", Tx_Start, 0);
    Rst = 1'b1;
    wait_start("post_rst_start", lat);
    Req = 4'b0000;
    wait_idle("post_rst_idle");

    repeat (3) @(negedge SysClk);
    check("scoreboard_empty", exp_id_q.size(), 0);
    check("grant_total", gnt_seen, 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
